// File: rtl/text_dump_tx_pkg.sv
// text_pkg: shared sizes, character codes and FSM encodings for the text dump transmitter
package text_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 24;
  localparam int ROW_W = 2;
  localparam int COL_W = 5;
  localparam int DATA_W = 8;
  localparam int CNT_W = $clog2(COLS);
  localparam logic [COL_W-1:0] COL_START = COL_W'(24);
  localparam logic [DATA_W-1:0] CHAR_CR = 8'h0D;
  localparam logic [DATA_W-1:0] CHAR_LF = 8'h0A;
  localparam logic [DATA_W-1:0] CHAR_SP = 8'h20;
  typedef enum logic [2:0] {IDLE, RD, LATCH, ARM, ACK, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {CHAR, CR, LF} phase_t;
endpackage

// File: rtl/text_dump_tx_if.sv
// text_dump_tx_if: RAM read port and UART transmit handshake bundle
// master (dump engine): drives rd_row/rd_col/tx_data/tx_start, samples rd_data/tx_busy
// slave (RAM + UART side): the opposite directions
interface text_dump_tx_if;
  import text_pkg::*;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tx_data;
  logic tx_start;
  logic tx_busy;
  modport master (output rd_row, rd_col, tx_data, tx_start, input rd_data, tx_busy);
  modport slave (input rd_row, rd_col, tx_data, tx_start, output rd_data, tx_busy);
endinterface

// File: rtl/text_dump_tx_handshake.sv
// tx_handshake: strobe-and-wait decode for the ARM/ACK/DRAIN phases of one byte
// in_arm/in_ack/in_drain: sequencer is in that phase; tx_busy: UART busy
// tx_start: strobe (only while armed and UART idle); acked/drained: phase exit conditions
module tx_handshake (
  input  logic in_arm,
  input  logic in_ack,
  input  logic in_drain,
  input  logic tx_busy,
  output logic tx_start,
  output logic acked,
  output logic drained
);
  // Combinational strobe: it can never coincide with tx_busy, and it falls
  // with the async reset of the state register that drives in_arm.
  assign tx_start = in_arm & ~tx_busy;
  assign acked = in_ack & tx_busy;
  assign drained = in_drain & ~tx_busy;
endmodule

// File: rtl/text_dump_tx.sv
// text_dump_tx: dumps the ROWS x COLS character buffer over the UART, CR LF after each row
// clk/reset: clock, async active-low reset; start: one-cycle dump request
// bus (master): RAM read address/data and UART tx_data/tx_start/tx_busy
// busy: dump in progress; done: one-cycle pulse after the final LF is handed off
// Build option NUL_AS_SPACE_EN: send 0x00 cells as spaces
module text_dump_tx
  import text_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  text_dump_tx_if.master bus,
  output logic busy,
  output logic done
);
  state_t state, state_n;
  phase_t phase, phase_n;
  logic [ROW_W-1:0] row, row_n;
  logic [COL_W-1:0] col, col_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] txd, txd_n, rd_char;
  logic tx_start, acked, drained;
`ifdef NUL_AS_SPACE_EN
  assign rd_char = (bus.rd_data == '0) ? CHAR_SP : bus.rd_data;
`else
  assign rd_char = bus.rd_data;
`endif
  tx_handshake u_hs (
    .in_arm  (state == ARM),
    .in_ack  (state == ACK),
    .in_drain(state == DRAIN),
    .tx_busy (bus.tx_busy),
    .tx_start(tx_start),
    .acked   (acked),
    .drained (drained)
  );
  assign bus.rd_row = row;
  assign bus.rd_col = col;
  assign bus.tx_data = txd;
  assign bus.tx_start = tx_start;
  assign busy = (state != IDLE) && (state != DONE);
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      phase <= CHAR;
      row <= '0;
      col <= COL_START;
      cnt <= '0;
      txd <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      row <= row_n;
      col <= col_n;
      cnt <= cnt_n;
      txd <= txd_n;
    end
  always_comb begin
    state_n = state;
    phase_n = phase;
    row_n = row;
    col_n = col;
    cnt_n = cnt;
    txd_n = txd;
    case (state)
      IDLE: if (start) begin
        row_n = '0;
        col_n = COL_START;
        cnt_n = '0;
        phase_n = CHAR;
        state_n = RD;
      end
      RD: state_n = LATCH;
      LATCH: begin
        txd_n = rd_char;
        state_n = ARM;
      end
      ARM: state_n = tx_start ? ACK : ARM;
      ACK: state_n = acked ? DRAIN : ACK;
      DRAIN: if (drained) begin
        if (phase == CHAR && cnt != CNT_W'(COLS - 1)) begin
          cnt_n = cnt + 1'b1;
          col_n = col + 1'b1;
          state_n = RD;
        end else if (phase == CHAR) begin
          txd_n = CHAR_CR;
          phase_n = CR;
          state_n = ARM;
        end else if (phase == CR) begin
          txd_n = CHAR_LF;
          phase_n = LF;
          state_n = ARM;
        end else if (row != ROW_W'(ROWS - 1)) begin
          row_n = row + 1'b1;
          col_n = COL_START;
          cnt_n = '0;
          phase_n = CHAR;
          state_n = RD;
        end else state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_text_dump_tx.sv
// tb_text_dump_tx: directed self-checking bench for text_dump_tx with RAM and UART models
module tb_text_dump_tx;
  import text_pkg::*;
`ifdef NUL_AS_SPACE_EN
  localparam logic [7:0] NUL_EXP = 8'h20;
`else
  localparam logic [7:0] NUL_EXP = 8'h00;
`endif
  logic clk = 0, reset = 0, start = 0, hold_busy = 0, hold_r, busy, done;
  logic [7:0] ram [4][32];
  logic [7:0] rd_q;
  logic [7:0] rx[$];
  logic [6:0] ad[$];
  int ucnt, udly, ack_dly = 0, viol = 0, done_cnt = 0;
  int vectors = 0, miscompares = 0;
  text_dump_tx_if bus ();
  text_dump_tx dut (.clk(clk), .reset(reset), .start(start), .bus(bus), .busy(busy), .done(done));
  always #5 clk = ~clk;
  always @(posedge clk) rd_q <= ram[bus.rd_row][bus.rd_col];
  assign bus.rd_data = rd_q;
  assign bus.tx_busy = hold_r | (ucnt != 0 && udly == 0);
  always @(posedge clk or negedge reset)
    if (!reset) begin
      ucnt <= 0;
      udly <= 0;
      hold_r <= 0;
    end else begin
      hold_r <= hold_busy;
      if (bus.tx_start && bus.tx_busy) viol <= viol + 1;
      if (bus.tx_start) begin
        rx.push_back(bus.tx_data);
        ad.push_back({bus.rd_row, bus.rd_col});
        ucnt <= 10;
        udly <= ack_dly;
      end else if (udly != 0) udly <= udly - 1;
      else if (ucnt != 0) ucnt <= ucnt - 1;
    end
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_reset(string tag);
    check({tag, "_rd_row"}, 32'(bus.rd_row), 0);
    check({tag, "_rd_col"}, 32'(bus.rd_col), 24);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask
  task automatic pulse_start;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic wait_done;
    int n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 1);
  endtask
  task automatic wait_bytes(int k);
    int n = 0;
    while (rx.size() < k && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("bytes_reached", 32'(rx.size() >= k), 1);
  endtask
  function automatic int stream_errs(int nul_idx);
    int errs = 0;
    for (int i = 0; i < rx.size(); i++) begin
      int r = i / 26, k = i % 26;
      logic [7:0] e;
      logic [6:0] ea;
      e = k < 24 ? 8'(8'h41 + r) : (k == 24 ? 8'h0D : 8'h0A);
      if (i == nul_idx) e = NUL_EXP;
      ea = {r[1:0], 5'(24 + k)};
      if (rx[i] !== e) errs++;
      if (k < 24 && ad[i] !== ea) errs++;
    end
    return errs;
  endfunction
  task automatic check_dump(string tag, int nul_idx, int d0);
    repeat (2) @(negedge clk);
    check({tag, "_len"}, rx.size(), 104);
    check({tag, "_errs"}, stream_errs(nul_idx), 0);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask
  initial begin
    int d0, lat, n;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) ram[r][c] = 8'(8'h41 + r);
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset = 1;
    // Full dump: latency, stream, address order, start during DONE
    rx.delete(); ad.delete(); d0 = done_cnt;
    pulse_start();
    lat = 1;
    while (!bus.tx_start && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    check("busy_run", 32'(busy), 1);
    wait_done();
    start = 1;
    @(negedge clk) start = 0;
    check("done_start_ignored", 32'(busy), 0);
    check_dump("dump1", -1, d0);
    check("byte0", 32'(rx[0]), 32'h41);
    check("byte24_cr", 32'(rx[24]), 32'h0D);
    check("byte103_lf", 32'(rx[103]), 32'h0A);
    check("addr26", 32'(ad[26]), 32'h38);
    check("addr34", 32'(ad[34]), 32'h20);
    // Second start at byte 50 is ignored
    rx.delete(); ad.delete(); d0 = done_cnt;
    pulse_start();
    wait_bytes(50);
    pulse_start();
    wait_done();
    check_dump("dump2", -1, d0);
    // Reset during byte 30's ACK wait
    ack_dly = 5;
    rx.delete(); ad.delete();
    pulse_start();
    wait_bytes(31);
    check("ack_wait_busy", 32'(busy), 1);
    reset = 0;
    #1 check_reset("abort");
    @(negedge clk) reset = 1;
    ack_dly = 0;
    rx.delete(); ad.delete(); d0 = done_cnt;
    pulse_start();
    wait_done();
    check_dump("dump3", -1, d0);
    // Reset while tx_start is high drops it at once
    pulse_start();
    n = 0;
    while (!bus.tx_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("strobe_reached", 32'(bus.tx_start), 1);
    reset = 0;
    #1 check("async_drop", 32'(bus.tx_start), 0);
    @(negedge clk) reset = 1;
    // UART busy held before the first byte; NUL cell at (2,5)
    ram[2][5] = 8'h00;
    hold_busy = 1;
    @(negedge clk);
    rx.delete(); ad.delete(); d0 = done_cnt;
    pulse_start();
    n = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.tx_start) n++;
    end
    check("held_no_start", n, 0);
    hold_busy = 0;
    #1 check("release_same", 32'(bus.tx_start), 0);
    @(negedge clk) check("release_pulse", 32'(bus.tx_start), 1);
    @(negedge clk) check("release_single", 32'(bus.tx_start), 0);
    wait_done();
    check_dump("dump4", 65, d0);
    check("nul_byte", 32'(rx[65]), 32'(NUL_EXP));
    check("start_vs_busy", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
